// File: rtl/uart_rx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_if : load-path bus between the core and the UART receive peripheral
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
interface uart_rx_if;
  logic        rEn;
  logic        addr;
  logic [31:0] rdata;
  logic        irq;

  modport master (output rEn, output addr, input rdata, input irq);
  modport slave  (input rEn, input addr, output rdata, output irq);
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver with byte FIFO and DATA/STATUS read registers
// Optional even-parity bit when UART_RX_PARITY_EN is defined.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic rx,
  uart_rx_if.slave  bus
);

  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd5,
`endif
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              irq_q, irq_d;
  logic              parity_flag;
  logic              push, push_ok, pop, full, status_rd, frame_ev, rx_s;
  logic [31:0]       status_word;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d, par_ev;
  logic parity_err_q, parity_err_d;
`endif

  assign rx_s    = sync2_q;
  assign sync1_d = rx;
  assign sync2_d = sync1_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    frame_ev = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    par_ev    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_BIT) begin
          cnt_d = '0;
          bit_d = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_BIT) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == FULL_BIT) begin
          cnt_d     = '0;
          par_bad_d = ^{shift_q, rx_s};
          par_ev    = par_bad_d;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == FULL_BIT) begin
          cnt_d = '0;
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            push = !par_bad_q;
`else
            push = 1'b1;
`endif
            state_d = S_IDLE;
          end else begin
            // Line held low past the stop bit: wait for idle so a break
            // cannot start a bogus frame.
            frame_ev = 1'b1;
            state_d  = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pop is served first, so a push into a full FIFO during a pop fits.
  assign status_rd = bus.rEn && bus.addr;
  assign pop       = bus.rEn && !bus.addr && (count_q != '0);
  assign full      = (count_q == DEPTH_C);
  assign push_ok   = push && (!full || pop);

`ifdef UART_RX_PARITY_EN
  assign parity_flag  = parity_err_q;
  assign parity_err_d = (parity_err_q && !status_rd) || par_ev;
`else
  assign parity_flag  = 1'b0;
`endif

  assign status_word = {16'b0, 8'(count_q), 3'b0, parity_flag, frame_err_q,
                        overrun_q, full, (count_q != '0)};

  always_comb begin
    wr_ptr_d    = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q;
    if (push_ok && !pop) count_d = count_q + 1'b1;
    if (!push_ok && pop) count_d = count_q - 1'b1;
    overrun_d   = (overrun_q && !status_rd) || (push && !push_ok);
    frame_err_d = (frame_err_q && !status_rd) || frame_ev;
    irq_d       = (count_d != '0);
    rdata_d     = rdata_q;
    if (bus.rEn) begin
      if (bus.addr) rdata_d = status_word;
      else if (count_q != '0) rdata_d = {23'b0, 1'b1, mem_q[rd_ptr_q]};
      else rdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.irq   = irq_q;

endmodule
`default_nettype wire
